// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and constants for the FIFO drain / serial transmitter.
package fifo_tx_pkg;

  // Frame sequencer states; PARITY is skipped when parity is disabled.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Default word width and parity setting of the project FIFO.
  localparam int DATA_W_DEF    = 6;
  localparam int PARITY_EN_DEF = 1;

  // Serial bits per frame with the default settings: start + data + parity + stop.
  localparam int FRAME_BITS = 2 + DATA_W_DEF + PARITY_EN_DEF;

  // Width of a bit timer that must hold the value CLKS_PER_BIT.
  function automatic int timer_w(input int clks);
    return $clog2(clks + 1);
  endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// FIFO-side handshake plus serial line of the drain stage.
interface fifo_serial_tx_if #(
  parameter int DATA_W = 6
);
  logic              tx_en;
  logic              empty_n;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic              tx;
  logic              busy;

  // Driver side: supplies the FIFO head and enable, observes the line.
  modport master (output tx_en, empty_n, data_in, input pop, tx, busy);
  // Transmitter side.
  modport slave  (input tx_en, empty_n, data_in, output pop, tx, busy);
endinterface

// File: rtl/fifo_serial_tx_timer.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while running and flags the last
// cycle of each serial bit with a one-cycle tick.
module fifo_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = run && (cnt_q == TC);

  // Restart aligns the count to a frame launch; terminal count wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// FIFO drain stage: pops one word at a time and sends it as a UART-style
// frame (start, data LSB first, optional even parity, stop).
module fifo_serial_tx
  import fifo_tx_pkg::*;
#(
  parameter int DATA_W       = 6,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  fifo_serial_tx_if.slave  bus
);

  localparam int TW = timer_w(CLKS_PER_BIT);

  tx_state_e         state_q, state_d;
  logic              tx_q, tx_d;
  logic              pop_q, pop_d;
  logic              busy_q, busy_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q;
  logic              parity_q;
  logic              load, shift, tick;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] w);
    return ^w;
  endfunction

  fifo_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (TW)
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .run     (state_q != IDLE),
    .restart (load),
    .tick    (tick)
  );

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = 1'b1;
    pop_d     = 1'b0;
    busy_d    = 1'b1;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        // empty_n is only looked at here, so a stale flag cannot double-pop.
        if (bus.empty_n && bus.tx_en) begin
          state_d = START;
          tx_d    = 1'b0;
          pop_d   = 1'b1;
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (tick) begin
          if (bit_cnt_q == 3'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift     = 1'b1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        tx_d = parity_q;
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs; reset forces the line idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      pop_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      pop_q     <= pop_d;
      busy_q    <= busy_d;
    end
  end

  // Word capture on the popping edge, then shift right once per data bit.
  always_ff @(posedge clk) begin
    if (load) begin
      shift_q  <= bus.data_in;
      parity_q <= even_parity(bus.data_in);
    end else if (shift) begin
      shift_q  <= shift_q >> 1;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.pop  = pop_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: one default instance (4 clk/bit, parity) and one
// fast instance (1 clk/bit, no parity), table vectors, random words checked
// against a frame model, and hand-written multi-cycle sequences.
module tb_fifo_serial_tx;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fifo_serial_tx_if #(.DATA_W(6)) b1 ();
  fifo_serial_tx_if #(.DATA_W(6)) b2 ();

  fifo_serial_tx #(.DATA_W(6), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (b1)
  );

  fifo_serial_tx #(.DATA_W(6), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (b2)
  );

  logic [1:0] otx, opop, obusy;
  assign otx   = {b2.tx,   b1.tx};
  assign opop  = {b2.pop,  b1.pop};
  assign obusy = {b2.busy, b1.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         u;      // 0 = default instance, 1 = fast no-parity instance
    logic [5:0] d;
    logic [8:0] frame;  // expected serial bits, bit 0 sent first
  } vec_t;

  task automatic check(input bit ok, input string nm, input logic [79:0] act,
                       input logic [79:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  function automatic int cpb(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  function automatic int pen(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  // Reference frame: start 0, data LSB first, even parity if enabled, stop 1.
  function automatic logic [8:0] model_frame(input logic [5:0] d, input int pe);
    logic [8:0] f;
    int ones;
    ones = 0;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      f[i+1] = d[i];
      ones += int'(d[i]);
    end
    if (pe != 0) f[7] = 1'(ones % 2);
    return f;
  endfunction

  // Per-cycle line level after launch: each frame bit held c cycles, then idle.
  function automatic logic [63:0] expand(input logic [8:0] fr, input int nb, input int c);
    logic [63:0] w;
    w = '1;
    for (int k = 0; k < nb * c; k++) w[k] = fr[k / c];
    return w;
  endfunction

  task automatic set_in(input int u, input logic en, input logic e, input logic [5:0] d);
    if (u == 0) begin
      b1.tx_en = en; b1.empty_n = e; b1.data_in = d;
    end else begin
      b2.tx_en = en; b2.empty_n = e; b2.data_in = d;
    end
  endtask

  // Offer one word at a negedge, then record line, pop and busy per cycle.
  task automatic frame_run(input int u, input logic [5:0] d, input logic [8:0] fr,
                           input string nm);
    logic [63:0] obs, req, m;
    int nb, len, pops, busy_cnt;
    logic pop0;
    nb  = 8 + pen(u);
    len = nb * cpb(u);
    req = expand(fr, nb, cpb(u));
    obs = '1;
    pops = 0; busy_cnt = 0; pop0 = 1'b0;
    set_in(u, 1'b1, 1'b1, d);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_in(u, 1'b1, 1'b0, 6'h00);
        pop0 = opop[u];
      end
      obs[k] = otx[u];
      pops += int'(opop[u]);
      busy_cnt += int'(obusy[u]);
    end
    m = (64'd1 << (len + 1)) - 64'd1;
    check((obs & m) == (req & m), {nm, "_tx"}, 80'(obs & m), 80'(req & m));
    check(pop0 && pops == 1, {nm, "_pop"}, 80'(pops), 80'(1));
    check(busy_cnt == len, {nm, "_busy"}, 80'(busy_cnt), 80'(len));
  endtask

  vec_t vecs[7];

  initial begin
    logic bad;
    logic [5:0] fq[$];
    logic [79:0] obs80, req80;
    logic [63:0] w1, w2;
    int p1, p2, np;

    vecs[0] = '{0, 6'h2D, 9'b1_0_101101_0};
    vecs[1] = '{0, 6'h3F, 9'b1_0_111111_0};
    vecs[2] = '{0, 6'h01, 9'b1_1_000001_0};
    vecs[3] = '{0, 6'h00, 9'b1_0_000000_0};
    vecs[4] = '{1, 6'h15, 9'b1_1_010101_0};
    vecs[5] = '{1, 6'h2A, 9'b1_1_101010_0};
    vecs[6] = '{1, 6'h3F, 9'b1_1_111111_0};

    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 6'h00);
    set_in(1, 1'b0, 1'b0, 6'h00);
    repeat (3) @(negedge clk);
    check({otx, opop, obusy} == 6'b11_00_00, "reset_state",
          80'({otx, opop, obusy}), 80'(6'b11_00_00));
    rst = 1'b0;
    set_in(0, 1'b1, 1'b0, 6'h2D);
    set_in(1, 1'b1, 1'b0, 6'h2D);

    // Empty FIFO: the line must stay idle.
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if ({otx, opop, obusy} != 6'b11_00_00) bad = 1'b1;
    end
    check(!bad, "idle_empty", 80'({otx, opop, obusy}), 80'(6'b11_00_00));

    for (int i = 0; i < 7; i++)
      frame_run(vecs[i].u, vecs[i].d, vecs[i].frame, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      int u;
      logic [5:0] d;
      u = i % 2;
      d = 6'($urandom_range(0, 63));
      frame_run(u, d, model_frame(d, pen(u)), $sformatf("rnd%0d_%0h", i, d));
    end

    // Back-to-back pops from a two-word FIFO model.
    fq = '{6'h3F, 6'h01};
    b1.tx_en = 1'b1; b1.empty_n = 1'b1; b1.data_in = fq[0];
    np = 0; p1 = -1; p2 = -1; obs80 = '1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      obs80[k] = b1.tx;
      if (b1.pop) begin
        if (np == 0) p1 = k; else p2 = k;
        np++;
        if (fq.size() > 0) void'(fq.pop_front());
      end
      b1.empty_n = (fq.size() > 0);
      b1.data_in = (fq.size() > 0) ? fq[0] : 6'h00;
    end
    w1 = expand(model_frame(6'h3F, 1), 9, 4);
    w2 = expand(model_frame(6'h01, 1), 9, 4);
    for (int k = 0; k < 80; k++) req80[k] = (k < 37) ? w1[k] : w2[k-37];
    check(obs80 == req80, "b2b_tx", obs80, req80);
    check(np == 2 && p1 == 0, "b2b_pops", 80'(np), 80'(2));
    check(p2 - p1 == 37, "b2b_period", 80'(p2 - p1), 80'(37));

    // tx_en dropped during DATA with empty_n held high.
    set_in(0, 1'b1, 1'b1, 6'h2D);
    np = 0; obs80 = '1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 10) b1.tx_en = 1'b0;
      if (k < 37) obs80[k] = b1.tx;
      np += int'(b1.pop);
    end
    req80 = 80'(expand(model_frame(6'h2D, 1), 9, 4));
    req80[79:37] = '1;
    check(obs80 == req80, "txen_frame", obs80, req80);
    check(np == 1, "txen_no_pop", 80'(np), 80'(1));
    check(b1.busy == 1'b0, "txen_idle", 80'(b1.busy), 80'(0));
    b1.tx_en = 1'b1;
    @(negedge clk);
    check({b1.pop, b1.tx} == 2'b10, "txen_resume", 80'({b1.pop, b1.tx}), 80'(2'b10));
    b1.empty_n = 1'b0;
    repeat (40) @(negedge clk);

    // Reset during DATA bit 3 of 6'h07 (bit 3 is 0, so the line is low).
    set_in(0, 1'b1, 1'b1, 6'h07);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 0) b1.empty_n = 1'b0;
    end
    check(b1.tx == 1'b0, "pre_reset_tx", 80'(b1.tx), 80'(0));
    rst = 1'b1;
    #1;
    check({b1.tx, b1.busy, b1.pop} == 3'b100, "async_reset",
          80'({b1.tx, b1.busy, b1.pop}), 80'(3'b100));
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 1'b1, 1'b1, 6'h2D);
    @(negedge clk);
    check({b1.tx, b1.busy, b1.pop} == 3'b011, "post_reset_launch",
          80'({b1.tx, b1.busy, b1.pop}), 80'(3'b011));
    b1.empty_n = 1'b0;
    repeat (40) @(negedge clk);
    check(b1.busy == 1'b0 && b1.tx == 1'b1, "post_reset_done",
          80'({b1.busy, b1.tx}), 80'(2'b01));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
